// File: rtl/sram_fifo.sv
// ---------------------------------------------------------------------------
// sram_fifo -- synchronous show-ahead FIFO built on a single sram_1r1w.
//
// The SRAM's registered read is always aimed at the *next* head (rd_ptr after
// any dequeue this cycle). Its write-to-read bypass covers an enqueue into an
// empty queue. Together these present the head on dequeue_value with zero
// added latency, straight from the SRAM read register.
//
// Optional feature macro: SRAM_FIFO_GUARD_EN
//   defined   : enqueue while full / dequeue while empty are dropped, with a
//               simulation warning.
//   undefined : accept terms are the raw enqueue_en / dequeue_en; callers
//               must honour full and empty.
//
// Ports:
//   clk            in  1      rising-edge clock
//   reset          in  1      synchronous active-high reset
//   flush          in  1      discard contents (pointers/count to 0)
//   enqueue_en     in  1      write enqueue_value this cycle
//   enqueue_value  in  WIDTH  data to enqueue
//   full           out 1      count == SIZE (registered)
//   almost_full    out 1      count >= ALMOST_FULL_THRESHOLD (registered)
//   dequeue_en     in  1      pop the head this cycle
//   dequeue_value  out WIDTH  current head, valid while empty == 0
//   empty          out 1      count == 0 (registered)
//   almost_empty   out 1      count <= ALMOST_EMPTY_THRESHOLD (registered)
//
// Also contains sram_1r1w, the 1-read/1-write SRAM model used as storage.
// ---------------------------------------------------------------------------

// sram_1r1w -- SIZE x DATA_WIDTH memory, one write port, one registered read
// port. READ_DURING_WRITE="NEW_DATA" forwards same-address write data to the
// read register.
//   clk         in  1           clock
//   read_en     in  1           capture read_addr contents this cycle
//   read_addr   in  ADDR_WIDTH  read address
//   read_data   out DATA_WIDTH  registered read data
//   write_en    in  1           write write_data to write_addr
//   write_addr  in  ADDR_WIDTH  write address
//   write_data  in  DATA_WIDTH  write data
module sram_1r1w #(
    parameter int    DATA_WIDTH        = 32,
    parameter int    SIZE              = 64,
    parameter string READ_DURING_WRITE = "NEW_DATA",
    parameter int    ADDR_WIDTH        = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data
);
    localparam bit BYPASS = (READ_DURING_WRITE == "NEW_DATA");

    logic [DATA_WIDTH-1:0] mem_q [SIZE];
    logic [DATA_WIDTH-1:0] read_data_q;
    logic [DATA_WIDTH-1:0] read_data_d;

    always_comb begin
        read_data_d = read_data_q;
        if (read_en) begin
            if (BYPASS && write_en && (write_addr == read_addr)) begin
                read_data_d = write_data;
            end else begin
                read_data_d = mem_q[read_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[write_addr] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        read_data_q <= read_data_d;
    end

    assign read_data = read_data_q;
endmodule

module sram_fifo #(
    parameter int WIDTH                  = 64,
    parameter int SIZE                   = 64,
    parameter int ALMOST_FULL_THRESHOLD  = SIZE,
    parameter int ALMOST_EMPTY_THRESHOLD = 1,
    parameter int ADDR_WIDTH             = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             enqueue_en,
    input  logic [WIDTH-1:0] enqueue_value,
    output logic             full,
    output logic             almost_full,
    input  logic             dequeue_en,
    output logic [WIDTH-1:0] dequeue_value,
    output logic             empty,
    output logic             almost_empty
);
    localparam int COUNT_WIDTH = $clog2(SIZE + 1);
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(SIZE - 1);
    localparam logic [COUNT_WIDTH-1:0] SIZE_CNT  = COUNT_WIDTH'(SIZE);
    localparam logic [COUNT_WIDTH-1:0] AF_CNT    = COUNT_WIDTH'(ALMOST_FULL_THRESHOLD);
    localparam logic [COUNT_WIDTH-1:0] AE_CNT    = COUNT_WIDTH'(ALMOST_EMPTY_THRESHOLD);
    localparam logic AF_RESET = (ALMOST_FULL_THRESHOLD == 0);

    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic full_q, full_d;
    logic empty_q, empty_d;
    logic almost_full_q, almost_full_d;
    logic almost_empty_q, almost_empty_d;

    logic enq_ok, deq_ok;
    logic enq_fire, deq_fire;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

`ifdef SRAM_FIFO_GUARD_EN
    assign enq_ok = enqueue_en & ~full_q;
    assign deq_ok = dequeue_en & ~empty_q;
`else
    assign enq_ok = enqueue_en;
    assign deq_ok = dequeue_en;
`endif

    assign enq_fire = enq_ok & ~flush & ~reset;
    assign deq_fire = deq_ok & ~flush & ~reset;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_fire) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (deq_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
            unique case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + COUNT_WIDTH'(1);
                2'b01:   count_d = count_q - COUNT_WIDTH'(1);
                default: count_d = count_q;
            endcase
        end
        full_d         = (count_d == SIZE_CNT);
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= AF_CNT);
        almost_empty_d = (count_d <= AE_CNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= AF_RESET;
            almost_empty_q <= 1'b1;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

`ifdef SRAM_FIFO_GUARD_EN
`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && !flush) begin
            if (enqueue_en && full_q)
                $display("sram_fifo warning: enqueue while full dropped at %0t", $time);
            if (dequeue_en && empty_q)
                $display("sram_fifo warning: dequeue while empty ignored at %0t", $time);
        end
    end
`endif
`endif

    // Read address is the head as it will be after this cycle, so the
    // registered read data is the new head on the following cycle.
    sram_1r1w #(
        .DATA_WIDTH       (WIDTH),
        .SIZE             (SIZE),
        .READ_DURING_WRITE("NEW_DATA")
    ) u_sram (
        .clk       (clk),
        .read_en   (1'b1),
        .read_addr (rd_ptr_d),
        .read_data (dequeue_value),
        .write_en  (enq_fire),
        .write_addr(wr_ptr_q),
        .write_data(enqueue_value)
    );

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
endmodule

// File: tb/tb_sram_fifo.sv
// Testbench for sram_fifo (SIZE=5, AF=4, AE=1): directed sequences with
// literal expectations, then randomized traffic checked every cycle against
// a queue-based model of the FIFO contents.
module tb_sram_fifo;
    localparam int W    = 16;
    localparam int SIZE = 5;
    localparam int AF   = 4;
    localparam int AE   = 1;

    logic         clk = 1'b0;
    logic         reset, flush, enqueue_en, dequeue_en;
    logic [W-1:0] enqueue_value;
    logic         full, almost_full, empty, almost_empty;
    logic [W-1:0] dequeue_value;

    int passed = 0;
    int total  = 0;
    bit check_en = 1'b0;
    logic [W-1:0] mq[$];

    sram_fifo #(
        .WIDTH                 (W),
        .SIZE                  (SIZE),
        .ALMOST_FULL_THRESHOLD (AF),
        .ALMOST_EMPTY_THRESHOLD(AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .enqueue_en   (enqueue_en),
        .enqueue_value(enqueue_value),
        .full         (full),
        .almost_full  (almost_full),
        .dequeue_en   (dequeue_en),
        .dequeue_value(dequeue_value),
        .empty        (empty),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: the FIFO is a queue; illegal requests are simply not applied.
    always @(posedge clk) begin
        bit ea, da;
        if (reset || flush) begin
            mq.delete();
        end else begin
            ea = enqueue_en && (mq.size() < SIZE);
            da = dequeue_en && (mq.size() > 0);
            if (da) void'(mq.pop_front());
            if (ea) mq.push_back(enqueue_value);
        end
    end

    always @(negedge clk) begin
        int n;
        if (check_en) begin
            n = mq.size();
            chk("empty",        64'(empty),        64'(n == 0));
            chk("full",         64'(full),         64'(n == SIZE));
            chk("almost_full",  64'(almost_full),  64'(n >= AF));
            chk("almost_empty", 64'(almost_empty), 64'(n <= AE));
            if (n > 0) chk("head", 64'(dequeue_value), 64'(mq[0]));
        end
    end

    task automatic cyc(input logic e, input logic [W-1:0] v, input logic d,
                       input logic f, input logic r);
        enqueue_en    = e;
        enqueue_value = v;
        dequeue_en    = d;
        flush         = f;
        reset         = r;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; enqueue_en = 1'b0; dequeue_en = 1'b0;
        enqueue_value = '0;
        @(negedge clk);
        @(negedge clk);
        check_en = 1'b1;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full",  64'(full),  64'd0);
        chk("rst_ae",    64'(almost_empty), 64'd1);
        chk("rst_af",    64'(almost_full),  64'd0);

        cyc(1'b1, 16'h00A5, 1'b0, 1'b0, 1'b0);
        chk("a5_empty", 64'(empty), 64'd0);
        chk("a5_value", 64'(dequeue_value), 64'h00A5);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("a5_drained", 64'(empty), 64'd1);

        for (int i = 0; i < SIZE; i++) begin
            cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
            case (i)
                0: chk("fill_ae_c1", 64'(almost_empty), 64'd1);
                1: chk("fill_ae_c2", 64'(almost_empty), 64'd0);
                2: chk("fill_af_c3", 64'(almost_full),  64'd0);
                3: begin
                    chk("fill_af_c4",   64'(almost_full), 64'd1);
                    chk("fill_full_c4", 64'(full),        64'd0);
                end
                default: chk("fill_full_c5", 64'(full), 64'd1);
            endcase
        end
        for (int i = 0; i < SIZE; i++) begin
            chk("drain_order", 64'(dequeue_value), 64'(i));
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_empty", 64'(empty), 64'd1);

        cyc(1'b1, 16'd100, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'd101, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3 * SIZE; i++) begin
            chk("stream_head", 64'(dequeue_value), 64'(100 + i));
            cyc(1'b1, 16'(102 + i), 1'b1, 1'b0, 1'b0);
            chk("stream_cnt2", 64'({empty, almost_empty, almost_full}), 64'd0);
        end
        chk("stream_tail", 64'(dequeue_value), 64'(100 + 3 * SIZE));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

        cyc(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h0077, 1'b0, 1'b1, 1'b0);
        chk("flush_empty", 64'(empty), 64'd1);
        cyc(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
        chk("flush_new_head", 64'(dequeue_value), 64'h0011);
        chk("flush_nonempty", 64'(empty), 64'd0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

`ifdef SRAM_FIFO_GUARD_EN
        for (int i = 0; i < SIZE; i++) cyc(1'b1, 16'(16'h30 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0);
        chk("guard_full", 64'(full), 64'd1);
        cyc(1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < SIZE; i++) begin
            chk("guard_no_ff", 64'(dequeue_value), 64'(16'h30 + i));
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        chk("guard_drained", 64'(empty), 64'd1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("guard_deq_empty", 64'(empty), 64'd1);
        cyc(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
        chk("guard_head", 64'(dequeue_value), 64'h0022);
        chk("guard_cnt1", 64'({empty, almost_empty}), 64'b01);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 3000; i++) begin
            logic e, d, f, r;
            e = ($urandom_range(99) < 55) && (mq.size() < SIZE);
            d = ($urandom_range(99) < 50) && (mq.size() > 0);
            f = ($urandom_range(99) < 2);
            r = ($urandom_range(199) < 1);
            cyc(e, 16'($urandom), d, f, r);
        end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sram_fifo.md
# sram_fifo

Synchronous show-ahead FIFO whose storage is one `sram_1r1w` instance; this block is the initiator that drives the SRAM's read and write ports. It turns the SRAM's one-cycle registered read into a zero-latency head-of-queue output, so consumers see `dequeue_value` valid whenever `empty` is low. It serves deep queues (miss queues, IO request buffers) where flop-based FIFOs are too large.

## Interface
- `WIDTH`, 64: data width in bits.
- `SIZE`, 64: capacity in entries, ≥ 2; need not be a power of two.
- `ALMOST_FULL_THRESHOLD`, SIZE: `almost_full` asserts when count ≥ this; 1..SIZE.
- `ALMOST_EMPTY_THRESHOLD`, 1: `almost_empty` asserts when count ≤ this; 0..SIZE-1.
- `ADDR_WIDTH`, $clog2(SIZE): pointer width; derived, do not override.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: discard all contents.
- `enqueue_en` in 1: write `enqueue_value` this cycle.
- `enqueue_value` in WIDTH: data to enqueue.
- `full` out 1: count == SIZE.
- `almost_full` out 1: count ≥ ALMOST_FULL_THRESHOLD.
- `dequeue_en` in 1: pop the head this cycle.
- `dequeue_value` out WIDTH: current head; valid iff `empty` == 0.
- `empty` out 1: count == 0.
- `almost_empty` out 1: count ≤ ALMOST_EMPTY_THRESHOLD.

## Operation
- State: `wr_ptr`, `rd_ptr` (ADDR_WIDTH bits), `count` ($clog2(SIZE+1) bits). Each pointer wraps from SIZE-1 to 0 explicitly, not by modulo-2^n.
- SRAM instance: `DATA_WIDTH`=WIDTH, `SIZE`=SIZE, `READ_DURING_WRITE`="NEW_DATA". Write port: `write_en`=accepted enqueue, `write_addr`=`wr_ptr`, `write_data`=`enqueue_value`.
- Read port: `read_en`=1 every cycle. `read_addr`=`rd_ptr`+1 (wrapped) if the dequeue is accepted, else `rd_ptr`. `dequeue_value` = SRAM `read_data` directly, with no extra register.
- Because read is to the next head, and the write bypass covers enqueue-to-empty, `dequeue_value` always holds entry `rd_ptr` one cycle after any pointer or write change.
- Accepted enqueue advances `wr_ptr`. Accepted dequeue advances `rd_ptr`. `count` is +1, -1, or unchanged when both are accepted.
- `full`, `empty`, `almost_full`, `almost_empty` are registered, computed from next-count.
- Priority: `reset` > `flush` > enqueue/dequeue. `flush` sets pointers and count to 0 next cycle and ignores same-cycle enqueue/dequeue. SRAM contents are not cleared.
- Enqueue while `full` is illegal, even with a simultaneous dequeue. Dequeue while `empty` is illegal. Handling depends on Configuration.
- Enqueue and dequeue together when 0 < count < SIZE: both are accepted and count is unchanged.

## Timing
- Reset values: `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=(ALMOST_FULL_THRESHOLD==0 ? 1 : 0, always 0 in legal range). Pointers and count are 0. `dequeue_value` is undefined until the first enqueue.
- Enqueue-to-visible latency is 1: enqueue at cycle t into an empty FIFO gives `empty`=0 and `dequeue_value`=that data at t+1.
- Dequeue at t gives the next entry on `dequeue_value` at t+1. Full throughput is one enqueue plus one dequeue per cycle, with no bubbles.
- `flush` or `reset` asserted at t gives `empty`=1 at t+1. Asserting either mid-stream is legal at any cycle.
- Flags change only on the cycle after the causing event, never combinationally from inputs.

## Configuration
- `SRAM_FIFO_GUARD_EN` defined:
  - Enqueue while `full` is dropped: no write, pointers and count unchanged.
  - Dequeue while `empty` is ignored.
  - Each case gives a `$display` warning in simulation.
- `SRAM_FIFO_GUARD_EN` undefined:
  - No guard logic; accept terms are the raw `enqueue_en` and `dequeue_en`.
  - Illegal operations corrupt state.
  - Callers must obey `full` and `empty`.

## Test plan
- Reset, then enqueue 0xA5 at t: `empty` is 0 and `dequeue_value`=0xA5 at t+1. Dequeue at t+1: `empty`=1 at t+2.
- SIZE=5. Enqueue 0..4 back-to-back: `full`=1 after the 5th. Dequeue all 5 every cycle: values 0,1,2,3,4 in order, with `empty`=1 at the end.
- Hold count at 2. Enqueue and dequeue simultaneously for 3×SIZE cycles with incrementing data: output is an in-order sequence with no gaps, count stays 2, and pointers wrap cleanly.
- AF=4, AE=1. Fill 0→4: `almost_empty` drops when count=2 and `almost_full` rises when count=4, each one cycle after the causing enqueue.
- With 3 entries, `flush` with simultaneous enqueue 0x77: `empty`=1 next cycle. Then enqueue 0x11: head is 0x11, not stale data.
- With `SRAM_FIFO_GUARD_EN`: enqueue 0xFF while full, then drain. 0xFF never appears. Dequeue while empty leaves count at 0.
